// File: rtl/if_fetch_unit.sv
// In-order fetch front end: up to 2 requests in flight, wrong-epoch responses dropped, 2-entry output FIFO.
// Define FETCH_MISALIGN_CHECK_EN to flag and halt on misaligned redirect targets instead of forcing alignment.
module if_fetch_unit #(
    parameter int                         INST_WIDTH      = 32,
    parameter int                         INST_ADDR_WIDTH = 32,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst,
    input  logic                       stall_IF,
    input  logic                       redirect_IF,
    input  logic [INST_ADDR_WIDTH-1:0] redirect_target_IF,
    output logic                       imem_req_valid,
    output logic [INST_ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                       imem_req_ready,
    input  logic                       imem_rsp_valid,
    input  logic [INST_WIDTH-1:0]      imem_rsp_data,
    output logic [INST_ADDR_WIDTH-1:0] PC_IF_o,
    output logic [INST_ADDR_WIDTH-1:0] PC_plus_4_IF_o,
    output logic [INST_WIDTH-1:0]      INST_IF_o,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic                       fetch_misalign_o,
`endif
    output logic                       inst_valid_IF_o
);
    localparam int            AW      = INST_ADDR_WIDTH;
    localparam logic [AW-1:0] PC_STEP = AW'(4);

    logic [AW-1:0]         fetch_pc_q, fetch_pc_d;
    logic                  epoch_q, epoch_d;
    logic [1:0]            tag_cnt_q, tag_cnt_d, tag_cnt_ret;
    logic [AW-1:0]         tag_pc_q [2];
    logic [AW-1:0]         tag_pc_d [2];
    logic                  tag_ep_q [2];
    logic                  tag_ep_d [2];
    logic [1:0]            buf_cnt_q, buf_cnt_d, buf_cnt_pop;
    logic [AW-1:0]         buf_pc_q [2];
    logic [AW-1:0]         buf_pc_d [2];
    logic [INST_WIDTH-1:0] buf_inst_q [2];
    logic [INST_WIDTH-1:0] buf_inst_d [2];
    logic [2:0]            in_flight;
    logic                  halted, req_fire, rsp_take, rsp_keep, pop;
    logic [AW-1:0]         redirect_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic halt_q, halt_d;

    assign redirect_pc      = redirect_target_IF;
    assign halted           = halt_q;
    assign fetch_misalign_o = halt_q;

    always_comb begin
        halt_d = halt_q;
        if (redirect_IF) halt_d = |redirect_target_IF[1:0];
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) halt_q <= 1'b0;
        else         halt_q <= halt_d;
    end
`else
    assign redirect_pc = redirect_target_IF & ~AW'(3);
    assign halted      = 1'b0;
`endif

    // Stale tags still count toward the limit, which keeps the FIFO from ever overflowing.
    assign in_flight      = {1'b0, tag_cnt_q} + {1'b0, buf_cnt_q};
    assign imem_req_valid = !cpu_rst && !halted && !redirect_IF && (in_flight < 3'd2);
    assign imem_req_addr  = cpu_rst ? '0 : fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_take       = imem_rsp_valid && (tag_cnt_q != 2'd0);
    assign rsp_keep       = rsp_take && (tag_ep_q[0] == epoch_q) && !redirect_IF;
    assign pop            = inst_valid_IF_o && !stall_IF;

    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        epoch_d     = epoch_q;
        tag_pc_d    = tag_pc_q;
        tag_ep_d    = tag_ep_q;
        buf_pc_d    = buf_pc_q;
        buf_inst_d  = buf_inst_q;
        tag_cnt_ret = tag_cnt_q - {1'b0, rsp_take};
        buf_cnt_pop = buf_cnt_q - {1'b0, pop};
        tag_cnt_d   = tag_cnt_ret;
        buf_cnt_d   = buf_cnt_pop;

        if (rsp_take) begin
            tag_pc_d[0] = tag_pc_q[1];
            tag_ep_d[0] = tag_ep_q[1];
        end
        if (req_fire) begin
            tag_pc_d[tag_cnt_ret[0]] = fetch_pc_q;
            tag_ep_d[tag_cnt_ret[0]] = epoch_q;
            tag_cnt_d                = tag_cnt_ret + 2'd1;
            fetch_pc_d               = fetch_pc_q + PC_STEP;
        end

        if (pop) begin
            buf_pc_d[0]   = buf_pc_q[1];
            buf_inst_d[0] = buf_inst_q[1];
        end
        if (rsp_keep) begin
            buf_pc_d[buf_cnt_pop[0]]   = tag_pc_q[0];
            buf_inst_d[buf_cnt_pop[0]] = imem_rsp_data;
            buf_cnt_d                  = buf_cnt_pop + 2'd1;
        end

        // Redirect wins over any push or pop in the same cycle.
        if (redirect_IF) begin
            fetch_pc_d = redirect_pc;
            epoch_d    = ~epoch_q;
            buf_cnt_d  = 2'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            fetch_pc_q <= RESET_PC;
            epoch_q    <= 1'b0;
            tag_cnt_q  <= 2'd0;
            buf_cnt_q  <= 2'd0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            epoch_q    <= epoch_d;
            tag_cnt_q  <= tag_cnt_d;
            buf_cnt_q  <= buf_cnt_d;
        end
    end

    // NOTE: payload storage is not reset; the counts alone decide which entries are meaningful.
    always_ff @(posedge cpu_clk) begin
        tag_pc_q   <= tag_pc_d;
        tag_ep_q   <= tag_ep_d;
        buf_pc_q   <= buf_pc_d;
        buf_inst_q <= buf_inst_d;
    end

    assign inst_valid_IF_o = (buf_cnt_q != 2'd0);
    assign PC_IF_o         = inst_valid_IF_o ? buf_pc_q[0] : '0;
    assign PC_plus_4_IF_o  = inst_valid_IF_o ? (buf_pc_q[0] + PC_STEP) : '0;
    assign INST_IF_o       = inst_valid_IF_o ? buf_inst_q[0] : '0;

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter INST_WIDTH, default 32, instruction width in bits.
REQ-002 SHALL have parameter INST_ADDR_WIDTH, default 32, PC and address width in bits.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have port cpu_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port cpu_rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port stall_IF  input  1  downstream IF/ID register holds; no output pop.
REQ-007 SHALL have port redirect_IF  input  1  control-flow redirect (branch, jump, flush).
REQ-008 SHALL have port redirect_target_IF  input  INST_ADDR_WIDTH  new fetch PC.
REQ-009 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-010 SHALL have port imem_req_addr  output  INST_ADDR_WIDTH  fetch address.
REQ-011 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-012 SHALL have port imem_rsp_valid  input  1  in-order response valid, at least 1 cycle after acceptance.
REQ-013 SHALL have port imem_rsp_data  input  INST_WIDTH  fetched instruction.
REQ-014 SHALL have port PC_IF_o  output  INST_ADDR_WIDTH  PC of presented instruction.
REQ-015 SHALL have port PC_plus_4_IF_o  output  INST_ADDR_WIDTH  PC_IF_o + 4.
REQ-016 SHALL have port INST_IF_o  output  INST_WIDTH  presented instruction.
REQ-017 SHALL have port inst_valid_IF_o  output  1  outputs hold a valid instruction.
REQ-018 SHALL have port fetch_misalign_o  output  1  misaligned redirect flag; present only with REQ-036.

Function
REQ-019 SHALL keep fetch PC register; imem_req_addr = fetch PC.
REQ-020 SHALL advance fetch PC by 4, modulo 2^INST_ADDR_WIDTH, on each handshake (imem_req_valid and imem_req_ready).
REQ-021 SHALL assert imem_req_valid only when outstanding requests + buffered entries < 2, not halted, and redirect_IF low.
REQ-022 SHALL track up to 2 outstanding requests in order, each tagged with its PC and a 1-bit epoch.
REQ-023 SHALL, on redirect_IF, load fetch PC with redirect_target_IF, toggle epoch, and empty the output buffer in the same edge.
REQ-024 SHALL discard responses whose epoch tag differs from the current epoch; the tag entry still retires.
REQ-025 SHALL write a current-epoch response with its tagged PC into a 2-entry FIFO.
REQ-026 SHALL drive outputs from the FIFO head; inst_valid_IF_o = FIFO not empty.
REQ-027 SHALL pop the head when inst_valid_IF_o is high and stall_IF is low.
REQ-028 SHALL drive PC_IF_o, PC_plus_4_IF_o and INST_IF_o to 0 when inst_valid_IF_o is low.
REQ-029 SHALL support push and pop in the same cycle, including when the FIFO is full.
REQ-030 SHALL give redirect priority over push and pop in the same cycle; a response in that cycle is dropped.
REQ-031 SHALL present a response on the outputs 1 cycle after imem_rsp_valid, given no redirect.
REQ-032 SHALL ignore imem_rsp_valid when no request is outstanding.

Reset
REQ-033 SHALL, while cpu_rst is high, set fetch PC = RESET_PC, epoch = 0, outstanding = 0, FIFO empty, halt flag = 0.
REQ-034 SHALL, while cpu_rst is high, hold imem_req_valid = 0, inst_valid_IF_o = 0, all data outputs = 0, fetch_misalign_o = 0.
REQ-035 SHALL, on reset mid-transfer, drop pending responses; responses arriving after release with no request outstanding fall under REQ-032.

Configuration
REQ-036 SHALL, with FETCH_MISALIGN_CHECK_EN defined, set fetch_misalign_o and a halt flag when a redirect target has bits[1:0] != 0; while halted, no requests are issued; the next aligned redirect clears both.
REQ-037 SHALL, without FETCH_MISALIGN_CHECK_EN, omit fetch_misalign_o and force bits[1:0] of redirect targets to 0.

Verification
REQ-038 SHALL cover reset release, ready=1, 1-cycle memory -> requests at 0x0, 0x4, 0x8; INST at PC 0x0 valid on cycle 3 after release.
REQ-039 SHALL cover stall_IF held high for 4 cycles -> FIFO fills to 2, imem_req_valid low, outputs stable at the same PC.
REQ-040 SHALL cover redirect to 0x100 with 2 requests outstanding -> both responses dropped; next valid output PC = 0x100, PC_plus_4 = 0x104.
REQ-041 SHALL cover redirect, pop and response in the same cycle -> FIFO empty next cycle; no stale instruction presented.
REQ-042 SHALL cover a fetch PC of 0xFFFFFFFC -> next request address 0x00000000.
REQ-043 SHALL cover redirect to 0x102, with and without FETCH_MISALIGN_CHECK_EN -> with: flag high and no requests until redirect to 0x200; without: fetch from 0x100.
